// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake and status bundle between uart_rx and its consumer
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output busy,
    output frame_err,
    output overrun,
    output parity_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  busy,
    input  frame_err,
    input  overrun,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with mid-bit sampling and valid/ready holding register; UART_RX_PARITY_EN adds even parity
module uart_rx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  uart_rx_if.master     bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 busy_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 frame_ok;

`ifdef UART_RX_PARITY_EN
  logic par;
  logic par_bad;
  logic parity_err_r;
  assign frame_ok       = ~par_bad;
  assign bus.parity_err = parity_err_r;
`else
  assign frame_ok       = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.busy      = busy_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par          <= 1'b0;
      par_bad      <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      // A completion in the STOP branch below may reload the register this cycle.
      if (rx_valid_r && bus.rx_ready) begin
        rx_valid_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_r <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_BIT) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par     <= 1'b0;
              par_bad <= 1'b0;
`endif
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            par   <= par ^ rx_s;
`endif
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt          <= '0;
            par_bad      <= par ^ rx_s;
            parity_err_r <= par ^ rx_s;
            state        <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              if (frame_ok) begin
                if (!rx_valid_r || bus.rx_ready) begin
                  rx_data_r  <= shift;
                  rx_valid_r <= 1'b1;
                end else begin
                  overrun_r <= 1'b1;
                end
              end
            end else begin
              frame_err_r <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // A held-low break must end before another start bit can be recognised.
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end

        default: begin
          cnt    <= '0;
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (parity cases under UART_RX_PARITY_EN)
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MIN = 106;
  localparam int LAT_MAX = 109;
`else
  localparam int LAT_MIN = 96;
  localparam int LAT_MAX = 99;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int busy_cycles = 0;
  int lat = 0;
  logic [7:0] last_data = 8'h00;
  logic valid_q = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
    if (bus.parity_err === 1'b1) pe_cnt++;
    if (bus.busy === 1'b1) busy_cycles++;
    if (bus.rx_valid === 1'b1 && valid_q !== 1'b1) begin
      rv_cnt++;
      last_data = bus.rx_data;
      lat = cyc - start_cyc;
    end
    valid_q = bus.rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Assumes the caller is aligned 1 ns after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip);
`else
    if (flip) rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    int b_rv, b_fe, b_ov, b_pe, b_busy;
    reset = 1'b1;
    rx = 1'b1;
    bus.rx_ready = 1'b0;
    tick(3);
    n_checks++;
    if (bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL reset_during valid=%b busy=%b want 0/0", bus.rx_valid, bus.busy);
    else n_pass++;
    reset = 1'b0;
    b_rv = rv_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_pe = pe_cnt; b_busy = busy_cycles;
    tick(1000);
    n_checks++;
    if (busy_cycles - b_busy !== 0) $display("FAIL idle_busy cycles=%0d want 0", busy_cycles - b_busy);
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 8'h00) $display("FAIL idle_data got=%h want 00", bus.rx_data);
    else n_pass++;
    n_checks++;
    if (rv_cnt - b_rv !== 0 || bus.rx_valid !== 1'b0) $display("FAIL idle_valid rises=%0d valid=%b want 0", rv_cnt - b_rv, bus.rx_valid);
    else n_pass++;
    n_checks++;
    if (fe_cnt - b_fe !== 0 || ov_cnt - b_ov !== 0 || pe_cnt - b_pe !== 0)
      $display("FAIL idle_errs fe=%0d ov=%0d pe=%0d want 0", fe_cnt - b_fe, ov_cnt - b_ov, pe_cnt - b_pe);
    else n_pass++;
  endtask

  task automatic test_basic;
    int b_rv, b_fe, b_ov, b_pe;
    bus.rx_ready = 1'b1;
    b_rv = rv_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_pe = pe_cnt;
    send_frame(8'h41, 1'b1, 1'b0);
    tick(20);
    n_checks++;
    if (rv_cnt - b_rv !== 1) $display("FAIL basic_count rises=%0d want 1", rv_cnt - b_rv);
    else n_pass++;
    n_checks++;
    if (last_data !== 8'h41) $display("FAIL basic_data got=%h want 41", last_data);
    else n_pass++;
    n_checks++;
    if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL basic_latency got=%0d want %0d..%0d", lat, LAT_MIN, LAT_MAX);
    else n_pass++;
    n_checks++;
    if (bus.rx_valid !== 1'b0) $display("FAIL basic_consumed valid=%b want 0", bus.rx_valid);
    else n_pass++;
    n_checks++;
    if (fe_cnt - b_fe !== 0 || ov_cnt - b_ov !== 0 || pe_cnt - b_pe !== 0)
      $display("FAIL basic_errs fe=%0d ov=%0d pe=%0d want 0", fe_cnt - b_fe, ov_cnt - b_ov, pe_cnt - b_pe);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int b_rv, b_ov;
    bus.rx_ready = 1'b0;
    b_rv = rv_cnt; b_ov = ov_cnt;
    send_frame(8'h41, 1'b1, 1'b0);
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h41) $display("FAIL b2b_first valid=%b data=%h want 1/41", bus.rx_valid, bus.rx_data);
    else n_pass++;
    send_frame(8'h44, 1'b1, 1'b0);
    tick(5);
    n_checks++;
    if (ov_cnt - b_ov !== 1) $display("FAIL b2b_overrun pulses=%0d want 1", ov_cnt - b_ov);
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 8'h41 || bus.rx_valid !== 1'b1) $display("FAIL b2b_hold data=%h valid=%b want 41/1", bus.rx_data, bus.rx_valid);
    else n_pass++;
    n_checks++;
    if (rv_cnt - b_rv !== 1) $display("FAIL b2b_rises rises=%0d want 1", rv_cnt - b_rv);
    else n_pass++;
    bus.rx_ready = 1'b1;
    tick(1);
    n_checks++;
    if (bus.rx_valid !== 1'b0) $display("FAIL b2b_drain valid=%b want 0", bus.rx_valid);
    else n_pass++;
  endtask

  task automatic test_patterns;
    logic [7:0] pats [4];
    int b_rv;
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h80; pats[3] = 8'h01;
    bus.rx_ready = 1'b1;
    b_rv = rv_cnt;
    for (int i = 0; i < 4; i++) begin
      send_frame(pats[i], 1'b1, 1'b0);
      n_checks++;
      if (rv_cnt - b_rv !== i + 1 || last_data !== pats[i])
        $display("FAIL pattern_%0d rises=%0d data=%h want %0d/%h", i, rv_cnt - b_rv, last_data, i + 1, pats[i]);
      else n_pass++;
    end
    tick(10);
  endtask

  task automatic test_glitch;
    int b_rv, b_fe, b_busy, n;
    b_rv = rv_cnt; b_fe = fe_cnt; b_busy = busy_cycles;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 8) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL glitch_busy_clear busy=%b after %0d clocks want 0", bus.busy, n);
    else n_pass++;
    n_checks++;
    if (busy_cycles - b_busy < 1) $display("FAIL glitch_start busy_cycles=%0d want >0", busy_cycles - b_busy);
    else n_pass++;
    tick(100);
    n_checks++;
    if (rv_cnt - b_rv !== 0) $display("FAIL glitch_valid rises=%0d want 0", rv_cnt - b_rv);
    else n_pass++;
    n_checks++;
    if (fe_cnt - b_fe !== 0) $display("FAIL glitch_ferr pulses=%0d want 0", fe_cnt - b_fe);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int b_rv, b_fe;
    bus.rx_ready = 1'b1;
    b_rv = rv_cnt; b_fe = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(30);
    n_checks++;
    if (fe_cnt - b_fe !== 1) $display("FAIL ferr_pulse pulses=%0d want 1", fe_cnt - b_fe);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL ferr_busy_held busy=%b want 1", bus.busy);
    else n_pass++;
    n_checks++;
    if (rv_cnt - b_rv !== 0) $display("FAIL ferr_valid rises=%0d want 0", rv_cnt - b_rv);
    else n_pass++;
    rx = 1'b1;
    tick(6);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL ferr_busy_release busy=%b want 0", bus.busy);
    else n_pass++;
    send_frame(8'h12, 1'b1, 1'b0);
    tick(10);
    n_checks++;
    if (rv_cnt - b_rv !== 1 || last_data !== 8'h12) $display("FAIL ferr_recover rises=%0d data=%h want 1/12", rv_cnt - b_rv, last_data);
    else n_pass++;
    n_checks++;
    if (fe_cnt - b_fe !== 1) $display("FAIL ferr_recover_clean pulses=%0d want 1", fe_cnt - b_fe);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int b_rv, b_fe, b_pe;
    logic [7:0] d;
    d = 8'hA5;
    bus.rx_ready = 1'b1;
    b_rv = rv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    tick(5);
    reset = 1'b1;
    rx = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0) $display("FAIL midreset_clear busy=%b valid=%b want 0/0", bus.busy, bus.rx_valid);
    else n_pass++;
    tick(3);
    reset = 1'b0;
    tick(20);
    n_checks++;
    if (rv_cnt - b_rv !== 0 || bus.busy !== 1'b0) $display("FAIL midreset_quiet rises=%0d busy=%b want 0/0", rv_cnt - b_rv, bus.busy);
    else n_pass++;
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(10);
    n_checks++;
    if (rv_cnt - b_rv !== 1 || last_data !== 8'h3C) $display("FAIL midreset_next rises=%0d data=%h want 1/3c", rv_cnt - b_rv, last_data);
    else n_pass++;
    n_checks++;
    if (fe_cnt - b_fe !== 0 || pe_cnt - b_pe !== 0) $display("FAIL midreset_errs fe=%0d pe=%0d want 0/0", fe_cnt - b_fe, pe_cnt - b_pe);
    else n_pass++;
`ifdef UART_RX_PARITY_EN
    b_rv = rv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    tick(10);
    n_checks++;
    if (pe_cnt - b_pe !== 1) $display("FAIL parity_pulse pulses=%0d want 1", pe_cnt - b_pe);
    else n_pass++;
    n_checks++;
    if (rv_cnt - b_rv !== 0 || fe_cnt - b_fe !== 0) $display("FAIL parity_drop rises=%0d fe=%0d want 0/0", rv_cnt - b_rv, fe_cnt - b_fe);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_patterns();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises the asynchronous serial input `rx` into bytes for the processor's load/control logic.
- Sits directly downstream of the board `rx` pin and upstream of the program/data loader inside the root system.
- Samples each bit at mid-bit using a clock-count baud timer.
- Delivers each byte through a valid/ready holding register and flags framing and overrun errors.

Parameters:
CLKS_PER_BIT, 10, system clocks per serial bit (100 ns bit at 10 ns clock); legal range 4..65535
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8
HALF_BIT, (CLKS_PER_BIT-1)/2, derived: clocks from start detect to start-bit sample (integer floor)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
busy  output  1  frame reception in progress
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because holding register full
parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset values: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, parity_err=0, FSM=IDLE, baud counter=0, bit index=0. The 2-FF synchroniser on rx resets to 1.
- All FSM decisions use the synchronised rx (rx_s), which lags the pin by 2 clocks.
- The baud counter has width clog2(CLKS_PER_BIT) and clears on every state change.
- FSM states:
  - IDLE: if rx_s==0, go to START.
  - START: when counter==HALF_BIT, sample rx_s. If 0, go to DATA with bit index 0. If 1 (glitch), go to IDLE with no error.
  - DATA: when counter==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (LSB-first). After the DATA_BITS-th sample, go to STOP (PARITY when the feature is enabled).
  - STOP: when counter==CLKS_PER_BIT-1, sample rx_s.
    - If 1: complete the byte and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. A break does not retrigger.
- busy=1 in every state except IDLE.
- Byte completion:
  - If rx_valid==0, or rx_valid & rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - Otherwise: keep the old byte and pulse overrun for one cycle.
- Handshake:
  - rx_valid clears on the clock after a cycle with rx_valid & rx_ready, unless a completion reloads it in that same cycle.
  - rx_ready while rx_valid==0 has no effect.
- Latency (defaults): rx_valid rises 96..99 clocks after the pin falling edge of the start bit.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample is detected with no lost frames.
- Asynchronous reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. After release, a line held low is treated as a new start bit.
- Error pulses never coincide with setting rx_valid for the same frame.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state follows DATA and samples one extra bit at CLKS_PER_BIT-1.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - On mismatch: pulse parity_err, discard the byte, still check the stop bit, with no rx_valid.
  - Frame length is DATA_BITS+3 bits.
- Undefined:
  - There is no PARITY state, and parity_err is tied to 0.
  - Frame length is DATA_BITS+2 bits.

Test Plan:
- Reset, rx=1 for 1000 clocks -> all outputs 0, busy=0 throughout.
- Send 0x41 (start, bits 1,0,0,0,0,0,1,0, stop; 10 clocks/bit), rx_ready=1 -> rx_valid pulses once 96..99 clocks after start edge, rx_data=0x41, no error pulses.
- Send 0x41 then 0x44 back-to-back, rx_ready=0 -> after the first frame rx_data=0x41 and rx_valid=1. At the second completion, one overrun pulse, rx_data still 0x41. Raise rx_ready -> rx_valid drops next clock.
- Low glitch of 3 clocks on idle line -> START aborts, busy returns to 0 within 8 clocks, no rx_valid, no frame_err.
- Frame 0x55 with stop bit forced 0, line held low 30 more clocks, then high -> one frame_err pulse, no rx_valid, busy stays 1 until the line returns high. A following 0x12 is received correctly.
- Assert reset at data bit 4 of 0xA5, release, send 0x3C -> no output from the aborted frame, rx_data=0x3C. With UART_RX_PARITY_EN, 0x3C with parity bit 1 -> parity_err pulse, no rx_valid.
